// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-port data memory.
// Misaligned accesses are answered with an error and never reach memory.
module dm_arbiter #(
   parameter int unsigned ADDR_W        = 32,
   parameter logic        RR_RESET_LAST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [2:0]        m0_op,
   input  logic [31:0]       m0_pc,
   output logic              m0_ready,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   output logic              m0_err,

   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [2:0]        m1_op,
   input  logic [31:0]       m1_pc,
   output logic              m1_ready,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              m1_err,

   output logic [ADDR_W-1:0] dm_A,
   output logic [31:0]       dm_WD,
   output logic [2:0]        dm_Op,
   output logic [31:0]       dm_PC,
   input  logic [31:0]       dm_RD
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e              r_state, w_state_d;
   logic                r_last, r_port, r_mis;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata, r_pc;
   logic [2:0]          r_op;
   logic [31:0]         r_rdata0, r_rdata1;
   logic                r_err0, r_err1;

   logic                w_grant, w_grant_port;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [31:0]         w_sel_wdata, w_sel_pc;
   logic [2:0]          w_sel_op;
   logic                w_sel_mis;
   logic [31:0]         w_load_data;

   function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] a);
      case (op)
         3'd2, 3'd3, 3'd6: return a[0];
         3'd4, 3'd7:       return a != 2'b00;
         default:          return 1'b0;
      endcase
   endfunction

   // On a tie the port that was not granted last wins.
   always_comb begin
      w_grant      = 1'b0;
      w_grant_port = 1'b0;
      if (r_state == StIdle && !reset) begin
         if (m0_req && m1_req) begin
            w_grant      = 1'b1;
            w_grant_port = ~r_last;
         end else if (m0_req) begin
            w_grant      = 1'b1;
            w_grant_port = 1'b0;
         end else if (m1_req) begin
            w_grant      = 1'b1;
            w_grant_port = 1'b1;
         end
      end
   end

   assign w_sel_addr  = w_grant_port ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_grant_port ? m1_wdata : m0_wdata;
   assign w_sel_op    = w_grant_port ? m1_op    : m0_op;
   assign w_sel_pc    = w_grant_port ? m1_pc    : m0_pc;
   assign w_sel_mis   = f_misaligned(w_sel_op, w_sel_addr[1:0]);

   assign m0_ready = w_grant & ~w_grant_port;
   assign m1_ready = w_grant &  w_grant_port;

   assign m0_rvalid = (r_state == StResp) & ~reset & ~r_port;
   assign m1_rvalid = (r_state == StResp) & ~reset &  r_port;
   assign m0_rdata  = r_rdata0;
   assign m1_rdata  = r_rdata1;
   assign m0_err    = r_err0;
   assign m1_err    = r_err1;

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:   if (w_grant) w_state_d = StAccess;
         StAccess: w_state_d = StResp;
         StResp:   w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   // Memory is only driven in an aligned ACCESS; Op=0 elsewhere is a harmless read.
   always_comb begin
      dm_A  = '0;
      dm_WD = '0;
      dm_Op = 3'd0;
      dm_PC = '0;
      if (r_state == StAccess && !reset && !r_mis) begin
         dm_A  = r_addr;
         dm_WD = r_wdata;
         dm_Op = r_op;
         dm_PC = r_pc;
      end
   end

   assign w_load_data = (!r_mis && r_op <= 3'd4) ? dm_RD : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_last   <= RR_RESET_LAST;
         r_port   <= 1'b0;
         r_mis    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_op     <= 3'd0;
         r_pc     <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_grant) begin
            r_last  <= w_grant_port;
            r_port  <= w_grant_port;
            r_mis   <= w_sel_mis;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_op    <= w_sel_op;
            r_pc    <= w_sel_pc;
         end
         if (r_state == StAccess) begin
            if (r_port) begin
               r_rdata1 <= w_load_data;
               r_err1   <= r_mis;
            end else begin
               r_rdata0 <= w_load_data;
               r_err0   <= r_mis;
            end
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: byte-array memory behind the arbiter, and a
// transaction-level reference model predicting grants, latency and response data.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_pc, m1_pc;
   logic [2:0]  m0_op, m1_op;
   logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] dm_A, dm_WD, dm_PC, dm_RD;
   logic [2:0]  dm_Op;

   int n_pass  = 0;
   int n_total = 0;

   dm_arbiter #(.ADDR_W(32), .RR_RESET_LAST(1'b1)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_op(m0_op), .m0_pc(m0_pc),
      .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_op(m1_op), .m1_pc(m1_pc),
      .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .dm_A(dm_A), .dm_WD(dm_WD), .dm_Op(dm_Op), .dm_PC(dm_PC), .dm_RD(dm_RD)
   );

   always #5 clk = ~clk;

   // Memory environment: combinational, op-extended reads; stores commit at the clock edge.
   logic [7:0] mem [256] = '{default: 8'h00};
   logic [7:0] w_a;
   always_comb begin
      w_a = dm_A[7:0];
      case (dm_Op)
         3'd0: dm_RD = {{24{mem[w_a][7]}}, mem[w_a]};
         3'd1: dm_RD = {24'd0, mem[w_a]};
         3'd2: dm_RD = {{16{mem[w_a+8'd1][7]}}, mem[w_a+8'd1], mem[w_a]};
         3'd3: dm_RD = {16'd0, mem[w_a+8'd1], mem[w_a]};
         3'd4: dm_RD = {mem[w_a+8'd3], mem[w_a+8'd2], mem[w_a+8'd1], mem[w_a]};
         default: dm_RD = 32'd0;
      endcase
   end
   always @(posedge clk) begin
      case (dm_Op)
         3'd5: mem[dm_A[7:0]] <= dm_WD[7:0];
         3'd6: begin
            mem[dm_A[7:0]]       <= dm_WD[7:0];
            mem[dm_A[7:0]+8'd1]  <= dm_WD[15:8];
         end
         3'd7: begin
            mem[dm_A[7:0]]       <= dm_WD[7:0];
            mem[dm_A[7:0]+8'd1]  <= dm_WD[15:8];
            mem[dm_A[7:0]+8'd2]  <= dm_WD[23:16];
            mem[dm_A[7:0]+8'd3]  <= dm_WD[31:24];
         end
         default: ;
      endcase
   end

   // Reference model: size-based alignment rule and little-endian byte arithmetic.
   logic [7:0] ref_mem [256] = '{default: 8'h00};
   task automatic ref_apply(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd, output logic er);
      int     size;
      longint val;
      size = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 :
             (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 : 4;
      rd = 32'd0;
      er = 1'b0;
      if (addr % size != 0) begin
         er = 1'b1;
      end else if (op >= 3'd5) begin
         for (int k = 0; k < size; k++) ref_mem[8'(addr + k)] = 8'(wdata >> (8 * k));
      end else begin
         val = 0;
         for (int k = 0; k < size; k++) val += longint'(ref_mem[8'(addr + k)]) << (8 * k);
         if ((op == 3'd0 || op == 3'd2) && val >= (longint'(1) << (8 * size - 1)))
            val -= longint'(1) << (8 * size);
         rd = 32'(val);
      end
   endtask

   task automatic drive(input int p, input logic req, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
      if (p == 0) begin
         m0_req = req; m0_op = op; m0_addr = addr; m0_wdata = wdata; m0_pc = pc;
      end else begin
         m1_req = req; m1_op = op; m1_addr = addr; m1_wdata = wdata; m1_pc = pc;
      end
   endtask

   function automatic logic rdy(input int p);
      return (p == 0) ? m0_ready : m1_ready;
   endfunction
   function automatic logic rv(input int p);
      return (p == 0) ? m0_rvalid : m1_rvalid;
   endfunction

   // One transaction on one port; reports relative cycles of ready/rvalid and the bus view.
   task automatic xact(input int p, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc,
                       output int t_acc, output int t_rsp, output logic [31:0] rd,
                       output logic er, output logic [2:0] a_op, output logic [31:0] a_a,
                       output logic [31:0] a_wd, output logic [31:0] a_pc,
                       output logic [2:0] op_or);
      t_acc = -1; t_rsp = -1; rd = 32'd0; er = 1'b0;
      a_op = 3'd0; a_a = 32'd0; a_wd = 32'd0; a_pc = 32'd0; op_or = 3'd0;
      @(negedge clk);
      drive(p, 1'b1, op, addr, wdata, pc);
      for (int i = 0; i < 12; i++) begin
         #1;
         op_or |= dm_Op;
         if (t_acc < 0 && rdy(p)) t_acc = i;
         if (t_acc >= 0 && i == t_acc + 1) begin
            a_op = dm_Op; a_a = dm_A; a_wd = dm_WD; a_pc = dm_PC;
         end
         if (rv(p)) begin
            t_rsp = i;
            rd    = (p == 0) ? m0_rdata : m1_rdata;
            er    = (p == 0) ? m0_err : m1_err;
            break;
         end
         @(negedge clk);
         if (t_acc >= 0) drive(p, 1'b0, op, addr, wdata, pc);
      end
      drive(p, 1'b0, op, addr, wdata, pc);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); else n_pass++;
      n_total++; if ({m0_err, m1_err} !== 2'b00) $display("FAIL rst_err: got %b want 00", {m0_err, m1_err}); else n_pass++;
      n_total++; if ({m0_rdata, m1_rdata} !== 64'd0) $display("FAIL rst_rdata: got %h want 0", {m0_rdata, m1_rdata}); else n_pass++;
      n_total++; if ({dm_Op, dm_A, dm_WD, dm_PC} !== 99'd0) $display("FAIL rst_dm: got op %0d a %h wd %h pc %h want 0", dm_Op, dm_A, dm_WD, dm_PC); else n_pass++;
      n_total++; if ({m0_ready, m1_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {m0_ready, m1_ready}); else n_pass++;
   endtask

   task automatic test_store_load();
      int t_acc, t_rsp;
      logic [31:0] rd, e_rd, a_a, a_wd, a_pc, pc;
      logic er, e_er;
      logic [2:0] a_op, op_or;
      pc = $urandom;
      ref_apply(3'd7, 32'h10, 32'hDEADBEEF, e_rd, e_er);
      xact(0, 3'd7, 32'h10, 32'hDEADBEEF, pc, t_acc, t_rsp, rd, er, a_op, a_a, a_wd, a_pc, op_or);
      n_total++; if (t_acc !== 0) $display("FAIL sw_ready_cycle: got %0d want 0", t_acc); else n_pass++;
      n_total++; if (t_rsp !== 2) $display("FAIL sw_rvalid_cycle: got %0d want 2", t_rsp); else n_pass++;
      n_total++; if (a_op !== 3'd7) $display("FAIL sw_dm_op: got %0d want 7", a_op); else n_pass++;
      n_total++; if ({a_a, a_wd, a_pc} !== {32'h10, 32'hDEADBEEF, pc}) $display("FAIL sw_dm_bus: got %h %h %h want 10 deadbeef %h", a_a, a_wd, a_pc, pc); else n_pass++;
      n_total++; if ({rd, er} !== {e_rd, e_er}) $display("FAIL sw_resp: got %h/%b want %h/%b", rd, er, e_rd, e_er); else n_pass++;
      ref_apply(3'd4, 32'h10, 32'd0, e_rd, e_er);
      xact(0, 3'd4, 32'h10, 32'd0, pc, t_acc, t_rsp, rd, er, a_op, a_a, a_wd, a_pc, op_or);
      n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h want deadbeef", rd); else n_pass++;
      n_total++; if ({rd, er} !== {e_rd, e_er}) $display("FAIL lw_resp: got %h/%b want %h/%b", rd, er, e_rd, e_er); else n_pass++;
   endtask

   task automatic test_misalign();
      int t_acc, t_rsp;
      logic [31:0] rd, e_rd, a_a, a_wd, a_pc;
      logic er, e_er;
      logic [2:0] a_op, op_or;
      ref_apply(3'd2, 32'h3, 32'd0, e_rd, e_er);
      xact(1, 3'd2, 32'h3, 32'd0, 32'h100, t_acc, t_rsp, rd, er, a_op, a_a, a_wd, a_pc, op_or);
      n_total++; if ({rd, er} !== {32'd0, 1'b1}) $display("FAIL lh_mis_resp: got %h/%b want 0/1", rd, er); else n_pass++;
      n_total++; if (op_or !== 3'd0) $display("FAIL lh_mis_dm_op: got %0d want 0", op_or); else n_pass++;
      n_total++; if (t_rsp - t_acc !== 2) $display("FAIL lh_mis_latency: got %0d want 2", t_rsp - t_acc); else n_pass++;
      ref_apply(3'd6, 32'h5, 32'h1234, e_rd, e_er);
      xact(1, 3'd6, 32'h5, 32'h1234, 32'h104, t_acc, t_rsp, rd, er, a_op, a_a, a_wd, a_pc, op_or);
      n_total++; if ({op_or, er} !== {3'd0, e_er}) $display("FAIL sh_mis: got op %0d err %b want op 0 err %b", op_or, er, e_er); else n_pass++;
      ref_apply(3'd1, 32'h5, 32'd0, e_rd, e_er);
      xact(1, 3'd1, 32'h5, 32'd0, 32'h108, t_acc, t_rsp, rd, er, a_op, a_a, a_wd, a_pc, op_or);
      n_total++; if ({rd, er} !== {e_rd, e_er}) $display("FAIL sh_mis_mem: got %h/%b want %h/%b", rd, er, e_rd, e_er); else n_pass++;
      ref_apply(3'd5, 32'h3, 32'h80, e_rd, e_er);
      xact(1, 3'd5, 32'h3, 32'h80, 32'h10c, t_acc, t_rsp, rd, er, a_op, a_a, a_wd, a_pc, op_or);
      n_total++; if ({rd, er} !== {e_rd, e_er}) $display("FAIL sb_resp: got %h/%b want %h/%b", rd, er, e_rd, e_er); else n_pass++;
      ref_apply(3'd0, 32'h3, 32'd0, e_rd, e_er);
      xact(1, 3'd0, 32'h3, 32'd0, 32'h110, t_acc, t_rsp, rd, er, a_op, a_a, a_wd, a_pc, op_or);
      n_total++; if ({rd, er} !== {32'hFFFF_FF80, 1'b0}) $display("FAIL lb_sext: got %h/%b want ffffff80/0", rd, er); else n_pass++;
      n_total++; if (rd !== e_rd) $display("FAIL lb_model: got %h want %h", rd, e_rd); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      drive(0, 1'b1, 3'd7, 32'h20, 32'h1234_5678, 32'h200);
      #1;
      n_total++; if (m0_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", m0_ready); else n_pass++;
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      reset = 1'b1;
      #1;
      n_total++; if (dm_Op !== 3'd0) $display("FAIL rmid_dm_op: got %0d want 0", dm_Op); else n_pass++;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 1) reset = 1'b0;
         #1;
         if (m0_rvalid || m1_rvalid) seen++;
      end
      n_total++; if (seen !== 0) $display("FAIL rmid_no_rvalid: got %0d pulses want 0", seen); else n_pass++;
   endtask

   // Both ports hit the same IDLE cycle right after a mid-transaction reset; port 0 must win.
   task automatic test_tie();
      int acc0, acc1, rv0, rv1;
      logic [31:0] d0, d1, e0, e1;
      logic x0, x1;
      acc0 = -1; acc1 = -1; rv0 = -1; rv1 = -1; d0 = 32'd0; d1 = 32'd0;
      ref_apply(3'd4, 32'h10, 32'd0, e0, x0);
      ref_apply(3'd4, 32'h20, 32'd0, e1, x1);
      @(negedge clk);
      drive(0, 1'b1, 3'd4, 32'h10, 32'd0, 32'h300);
      drive(1, 1'b1, 3'd4, 32'h20, 32'd0, 32'h304);
      for (int i = 0; i < 16; i++) begin
         #1;
         if (acc0 < 0 && m0_ready) acc0 = i;
         if (acc1 < 0 && m1_ready) acc1 = i;
         if (m0_rvalid) begin rv0 = i; d0 = m0_rdata; end
         if (m1_rvalid) begin rv1 = i; d1 = m1_rdata; end
         if (rv0 >= 0 && rv1 >= 0) break;
         @(negedge clk);
         if (acc0 >= 0) drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
         if (acc1 >= 0) drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      end
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      n_total++; if (acc0 !== 0) $display("FAIL tie_m0_ready: got %0d want 0", acc0); else n_pass++;
      n_total++; if (acc1 !== 3) $display("FAIL tie_m1_ready: got %0d want 3", acc1); else n_pass++;
      n_total++; if ({rv0, rv1} !== {32'd2, 32'd5}) $display("FAIL tie_rvalid: got %0d,%0d want 2,5", rv0, rv1); else n_pass++;
      n_total++; if ({d0, d1} !== {e0, e1}) $display("FAIL tie_rdata: got %h,%h want %h,%h", d0, d1, e0, e1); else n_pass++;
   endtask

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } req_t;

   // Random traffic from both ports; every cycle the ready and rvalid vectors are predicted.
   task automatic test_traffic(input int n_each, input int idle_pct);
      req_t q[2][$];
      req_t r;
      int   order[$];
      int   last, free_at, exp_at, exp_port, gp;
      logic req0, req1, eg0, eg1;
      logic [31:0] exp_rd, got_rd;
      logic exp_er, got_er;
      logic [1:0] exp_rv;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < n_each; k++) begin
            r.op    = 3'($urandom_range(0, 7));
            r.addr  = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) == 0) r.addr += 32'($urandom_range(1, 3));
            r.wdata = $urandom;
            r.pc    = $urandom;
            q[p].push_back(r);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      last = 1; free_at = 0; exp_at = -1; exp_port = 0; exp_rd = 32'd0; exp_er = 1'b0;
      for (int i = 0; i < 6 * n_each + 40; i++) begin
         @(negedge clk);
         req0 = q[0].size() > 0 && int'($urandom_range(0, 99)) >= idle_pct;
         req1 = q[1].size() > 0 && int'($urandom_range(0, 99)) >= idle_pct;
         if (req0) drive(0, 1'b1, q[0][0].op, q[0][0].addr, q[0][0].wdata, q[0][0].pc);
         else      drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
         if (req1) drive(1, 1'b1, q[1][0].op, q[1][0].addr, q[1][0].wdata, q[1][0].pc);
         else      drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
         #1;
         eg0 = 1'b0; eg1 = 1'b0;
         if (i >= free_at) begin
            if (req0 && req1) begin
               if (last == 0) eg1 = 1'b1; else eg0 = 1'b1;
            end else begin
               eg0 = req0;
               eg1 = req1;
            end
         end
         n_total++; if ({m1_ready, m0_ready} !== {eg1, eg0}) $display("FAIL trf_ready cyc %0d: got %b want %b", i, {m1_ready, m0_ready}, {eg1, eg0}); else n_pass++;
         exp_rv = (i == exp_at) ? ((exp_port == 1) ? 2'b10 : 2'b01) : 2'b00;
         n_total++; if ({m1_rvalid, m0_rvalid} !== exp_rv) $display("FAIL trf_rvalid cyc %0d: got %b want %b", i, {m1_rvalid, m0_rvalid}, exp_rv); else n_pass++;
         if (i == exp_at) begin
            got_rd = (exp_port == 1) ? m1_rdata : m0_rdata;
            got_er = (exp_port == 1) ? m1_err : m0_err;
            n_total++; if ({got_rd, got_er} !== {exp_rd, exp_er}) $display("FAIL trf_resp port %0d cyc %0d: got %h/%b want %h/%b", exp_port, i, got_rd, got_er, exp_rd, exp_er); else n_pass++;
         end
         if (eg0 || eg1) begin
            gp = eg1 ? 1 : 0;
            r  = q[gp].pop_front();
            ref_apply(r.op, r.addr, r.wdata, exp_rd, exp_er);
            last = gp; free_at = i + 3; exp_at = i + 2; exp_port = gp;
            order.push_back(gp);
         end
         if (q[0].size() == 0 && q[1].size() == 0 && i > exp_at) break;
      end
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
      n_total++; if (q[0].size() + q[1].size() !== 0) $display("FAIL trf_budget: got %0d left want 0", q[0].size() + q[1].size()); else n_pass++;
      if (idle_pct == 0) begin
         for (int k = 0; k < order.size(); k++) begin
            n_total++; if (order[k] !== k % 2) $display("FAIL trf_alternate #%0d: got port %0d want %0d", k, order[k], k % 2); else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_misalign();
      test_reset_mid();
      test_tie();
      test_traffic(3, 0);
      test_traffic(12, 40);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
